// File: rtl/motor_req_arbiter.sv
// motor_req_arbiter
//   Shares one bidirectional motor between NUM_REQ command sources.
//   Requests are granted round-robin. Each grant holds the motor off for
//   DEAD_CYCLES, then drives the latched direction until the target limit is
//   reached or the request drops. Both limits high while running latches a
//   fault. A travel-timeout watchdog is compiled in when MOTOR_ARB_TIMEOUT_EN
//   is defined.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   req        in   level request per source
//   req_dir    in   direction per source (1 = up), sampled only at grant
//   up_max     in   upper limit switch (1 = at top)
//   dn_max     in   lower limit switch (1 = at bottom)
//   fault_clr  in   clears a latched fault
//   up_M       out  motor up drive
//   dn_M       out  motor down drive
//   grant      out  one-hot current owner, zero when no owner
//   busy       out  high during dead time and travel
//   fault      out  high while a fault is latched
//
// Configuration macro: MOTOR_ARB_TIMEOUT_EN
module motor_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DEAD_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_dir,
  input  logic               up_max,
  input  logic               dn_max,
  input  logic               fault_clr,
  output logic               up_M,
  output logic               dn_M,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               fault
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMER_W-1:0] DEAD_LOAD = TIMER_W'(DEAD_CYCLES - 1);
`ifdef MOTOR_ARB_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

  if (NUM_REQ < 2 || DEAD_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_cfg_bad
    $error("motor_req_arbiter: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_RUN,
    S_FAULT
  } state_t;

  state_t             r_state, w_state_nx;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nx;
  logic [PTR_W-1:0]   r_owner, w_owner_nx;
  logic               r_dir, w_dir_nx;
  logic [TIMER_W-1:0] r_cnt, w_cnt_nx;
  logic               r_up, r_dn, r_busy, r_fault;
  logic [NUM_REQ-1:0] r_grant;

  logic               w_found;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_ptr_after;
  logic               w_at_target;
  logic               w_live;

  // Round-robin search starting at the pointer, wrapping at NUM_REQ.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    w_found = 1'b0;
    w_pick  = '0;
    v_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      v_idx = PTR_W'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
    w_ptr_after = PTR_W'((32'(w_pick) + 1) % NUM_REQ);
  end

  // Only the limit in the latched direction matters while travelling.
  assign w_at_target = r_dir ? up_max : dn_max;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_owner_nx = r_owner;
    w_dir_nx   = r_dir;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nx = w_pick;
          w_dir_nx   = req_dir[w_pick];
          w_ptr_nx   = w_ptr_after;
          w_cnt_nx   = DEAD_LOAD;
          w_state_nx = S_DEAD;
        end
      end
      S_DEAD: begin
        if (!req[r_owner]) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == '0) begin
          if (w_at_target) begin
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = S_RUN;
          end
        end else begin
          w_cnt_nx = r_cnt - TIMER_W'(1);
        end
      end
      S_RUN: begin
        if (up_max && dn_max) begin
          w_state_nx = S_FAULT;
        end else if (w_at_target || !req[r_owner]) begin
          w_state_nx = S_IDLE;
        end
`ifdef MOTOR_ARB_TIMEOUT_EN
        else if (r_cnt == TMO_LAST) begin
          w_state_nx = S_FAULT;
        end else begin
          w_cnt_nx = r_cnt + TIMER_W'(1);
        end
`endif
      end
      S_FAULT: begin
        if (fault_clr) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  assign w_live = (w_state_nx == S_DEAD) || (w_state_nx == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_owner <= w_owner_nx;
      r_dir   <= w_dir_nx;
      r_cnt   <= w_cnt_nx;
      r_up    <= (w_state_nx == S_RUN) && w_dir_nx;
      r_dn    <= (w_state_nx == S_RUN) && !w_dir_nx;
      r_grant <= w_live ? (NUM_REQ'(1) << w_owner_nx) : '0;
      r_busy  <= w_live;
      r_fault <= (w_state_nx == S_FAULT);
    end
  end

  assign up_M  = r_up;
  assign dn_M  = r_dn;
  assign grant = r_grant;
  assign busy  = r_busy;
  assign fault = r_fault;

endmodule

// File: tb/tb_motor_req_arbiter.sv
// tb_motor_req_arbiter
//   Bench for motor_req_arbiter with NUM_REQ=4, DEAD_CYCLES=4,
//   TIMEOUT_CYCLES=16. Timeout expectations follow MOTOR_ARB_TIMEOUT_EN.
//   Output word layout used throughout: {grant[3:0], up_M, dn_M, busy, fault}.
module tb_motor_req_arbiter;

  localparam int NR = 4;
  localparam int DC = 4;
  localparam int TC = 16;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_dir;
  logic       up_max;
  logic       dn_max;
  logic       fault_clr;
  logic       up_M;
  logic       dn_M;
  logic [3:0] grant;
  logic       busy;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  motor_req_arbiter #(
    .NUM_REQ(NR),
    .DEAD_CYCLES(DC),
    .TIMEOUT_CYCLES(TC),
    .TIMER_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_dir(req_dir),
    .up_max(up_max),
    .dn_max(dn_max),
    .fault_clr(fault_clr),
    .up_M(up_M),
    .dn_M(dn_M),
    .grant(grant),
    .busy(busy),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [7:0] outs();
    return {grant, up_M, dn_M, busy, fault};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] d,
                       input logic um, input logic dm, input logic fc);
    rst = r; req = q; req_dir = d; up_max = um; dn_max = dm; fault_clr = fc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner index (-1 = none), cycles since grant, travel length.
  int m_owner, m_ptr, m_elapsed, m_runcyc;
  bit m_dir, m_running, m_fault;

  function automatic bit bit_of(input logic [3:0] v, input int idx);
    return ((32'(v) >> idx) & 1) != 0;
  endfunction

  task automatic model_step();
    bit tgt;
    tgt = m_dir ? up_max : dn_max;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_running = 0; m_fault = 0;
    end else if (m_fault) begin
      if (fault_clr) m_fault = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (bit_of(req, c)) begin
          m_owner = c; m_dir = bit_of(req_dir, c); m_ptr = (c + 1) % NR;
          m_elapsed = 0; m_running = 0;
          break;
        end
      end
    end else if (!m_running) begin
      if (!bit_of(req, m_owner)) m_owner = -1;
      else begin
        m_elapsed++;
        if (m_elapsed == DC) begin
          if (tgt) m_owner = -1;
          else begin m_running = 1; m_runcyc = 0; end
        end
      end
    end else begin
      if (up_max && dn_max) begin
        m_owner = -1; m_running = 0; m_fault = 1;
      end else if (tgt || !bit_of(req, m_owner)) begin
        m_owner = -1; m_running = 0;
      end else begin
        m_runcyc++;
`ifdef MOTOR_ARB_TIMEOUT_EN
        if (m_runcyc == TC) begin m_owner = -1; m_running = 0; m_fault = 1; end
`endif
      end
    end
  endtask

  function automatic logic [7:0] model_outs();
    logic [3:0] g;
    bit live;
    live = (m_owner >= 0);
    g = live ? 4'(1 << m_owner) : 4'b0000;
    return {g, live && m_running && m_dir, live && m_running && !m_dir, live, m_fault};
  endfunction

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic [3:0] d;
    logic       um;
    logic       dm;
    logic       fc;
    logic [7:0] e;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [3:0] mask;
    int hi;

    // reset, abort in DEAD, up move (dir change after grant ignored), limit already set
    vt[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 8'h12};
    vt[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[5]  = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[6]  = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[7]  = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[8]  = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 8'h2A};
    vt[9]  = '{1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[10] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'h42};
    vt[11] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'h42};
    vt[12] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'h42};
    vt[13] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'h42};
    vt[14] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[15] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};

    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].r, vt[i].q, vt[i].d, vt[i].um, vt[i].dm, vt[i].fc);
      tick();
      check($sformatf("vec%0d", i), outs(), vt[i].e);
    end

    // Round-robin: 0001 first, then 1000 after one idle cycle.
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0); tick(); tick();
    drive(1'b0, 4'h9, 4'h1, 1'b0, 1'b0, 1'b0); tick();
    check("rr_first", outs(), 8'h12);
    repeat (4) tick();
    check("rr_run0", outs(), 8'h1A);
    up_max = 1'b1; tick();
    check("rr_release", outs(), 8'h00);
    tick();
    check("rr_next", outs(), 8'h82);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
    check("rr_drop", outs(), 8'h00);

    // Travel timeout.
    drive(1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0); tick();
    check("tmo_grant", outs(), 8'h12);
    hi = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (up_M) hi++;
      if (fault) break;
    end
`ifdef MOTOR_ARB_TIMEOUT_EN
    check("tmo_len", 8'(hi), 8'(TC));
    check("tmo_fault", outs(), 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fault_hold", outs(), 8'h01);
    end
    fault_clr = 1'b1; tick();
    check("fault_clr", outs(), 8'h00);
    fault_clr = 1'b0; tick();
    check("regrant", outs(), 8'h12);
`else
    check("notmo_len", 8'(hi), 8'd41);
    check("notmo_run", outs(), 8'h1A);
`endif
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
    check("tmo_drop", outs(), 8'h00);

    // Sensor fault while running down.
    drive(1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0); tick();
    check("sf_grant", outs(), 8'h22);
    repeat (4) tick();
    check("sf_run", outs(), 8'h26);
    up_max = 1'b1; dn_max = 1'b1; tick();
    check("sensor_fault", outs(), 8'h01);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    check("sf_clear", outs(), 8'h00);
    fault_clr = 1'b0;

    // Reset in the middle of a move.
    drive(1'b0, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0); tick();
    check("rm_grant", outs(), 8'h42);
    repeat (4) tick();
    check("rm_run", outs(), 8'h4A);
    rst = 1'b1; tick();
    check("rst_mid", outs(), 8'h00);

    // Randomised run against the reference model.
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    model_step(); tick();
    check("rand_rst", outs(), model_outs());
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      mask = 4'h0;
      for (int k = 0; k < NR; k++)
        if ($urandom_range(11) == 0) mask = mask | 4'(1 << k);
      req       = req ^ mask;
      req_dir   = 4'($urandom);
      up_max    = ($urandom_range(19) == 0);
      dn_max    = ($urandom_range(19) == 0);
      fault_clr = ($urandom_range(9) == 0);
      rst       = ($urandom_range(499) == 0);
      model_step();
      tick();
      check("rand", outs(), model_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
